// File: rtl/video_fetch_if.sv
// rtl/video_fetch_if.sv - burst read port between the frame fetcher and the SDRAM arbiter
interface video_fetch_if #(
    parameter int ADDR_W = 24
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/video_fetch.sv
// rtl/video_fetch.sv - show-ahead prefetch FIFO serving scan-out words, refilled by fixed bursts
module video_fetch #(
    parameter int ADDR_W      = 24,
    parameter int FRAME_WORDS = 153600,
    parameter int FIFO_DEPTH  = 32,
    parameter int BURST       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_sync,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              vid_req,
    output logic [31:0]       vid_data,
    output logic              underflow,
    video_fetch_if.master     mem
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(FRAME_WORDS + BURST) + 1;
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_FLUSH
    } state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W-1:0]    fetch_idx_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                underflow_q;

    logic [31:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic fifo_empty;
    logic push;
    logic pop;
    logic space_ok;
    logic fetch_more;
    logic last_beat;

    assign fifo_empty = (count_q == '0);
    // frame_sync empties the FIFO, so it suppresses both push and pop in its cycle
    assign push       = mem.mem_rvalid && (state_q == S_DATA) && !frame_sync;
    assign pop        = vid_req && !fifo_empty && !frame_sync;
    // Only one burst is ever outstanding, so the live count already accounts for it
    assign space_ok   = (count_q <= CNT_W'(FIFO_DEPTH - BURST));
    assign fetch_more = (fetch_idx_q < IDX_W'(FRAME_WORDS));
    assign last_beat  = (beat_q == BEAT_W'(BURST - 1));

    assign vid_data   = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_q];
    assign underflow  = underflow_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (frame_sync) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            base_q      <= '0;
            fetch_idx_q <= IDX_W'(FRAME_WORDS);
            beat_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (frame_sync) begin
                base_q      <= fb_base;
                fetch_idx_q <= '0;
                underflow_q <= 1'b0;
            end else if (vid_req && fifo_empty) begin
                underflow_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (!frame_sync && space_ok && fetch_more) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= base_q + ADDR_W'(fetch_idx_q);
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                        if (frame_sync) begin
                            state_q <= S_FLUSH;
                        end else begin
                            fetch_idx_q <= fetch_idx_q + IDX_W'(BURST);
                            state_q     <= S_DATA;
                        end
                    end else if (frame_sync) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                S_DATA, S_FLUSH: begin
                    // The beat count carries over into FLUSH so only the remainder is dropped
                    if (mem.mem_rvalid && last_beat) begin
                        beat_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        if (mem.mem_rvalid) begin
                            beat_q <= beat_q + 1'b1;
                        end
                        if (frame_sync) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_fetch.sv
// tb/tb_video_fetch.sv - randomized bench for video_fetch against a queue-based frame model
module tb_video_fetch;
    localparam int FRAME_W = 96;
    localparam int DEPTH   = 32;
    localparam int BURST   = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_sync = 1'b0;
    logic [23:0] fb_base = '0;
    logic        vid_req = 1'b0;
    logic [31:0] vid_data;
    logic        underflow;

    video_fetch_if #(.ADDR_W(24)) mem_if ();

    video_fetch #(
        .ADDR_W(24), .FRAME_WORDS(FRAME_W), .FIFO_DEPTH(DEPTH), .BURST(BURST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync), .fb_base(fb_base),
        .vid_req(vid_req), .vid_data(vid_data), .underflow(underflow), .mem(mem_if)
    );

    always #5 clk = ~clk;

    int err = 0;
    int chk = 0;

    // frame model: FIFO contents as a queue, sticky underflow, next fetch position
    logic [31:0] q[$];
    logic [31:0] pop_log[$];
    logic [23:0] ack_log[$];
    bit          m_uf;
    int          epoch;
    logic [23:0] m_base;
    int          m_idx;
    int          frame_acks;
    int          stall;

    // arbiter model
    bit          burst_on;
    int          beats_left;
    logic [23:0] beat_addr;
    int          burst_tag;
    int          lat_cnt;
    bit          req_seen;
    int          wait_cnt;
    int          ack_lo, ack_hi, lat_lo, lat_hi, gap_pct;

    bit          p_sync, p_vreq, p_ack, p_rv, s_mreq;
    logic [23:0] p_base, s_addr;
    logic [31:0] p_rd;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            if (err <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit was_empty;
        was_empty = (q.size() == 0);
        if (p_rv) begin
            if (!p_sync && burst_tag == epoch) q.push_back(p_rd);
            beats_left--;
            if (beats_left == 0) burst_on = 0;
        end
        if (p_ack) begin
            ack_log.push_back(s_addr);
            frame_acks++;
            check("req_within_frame", 32'(m_idx < FRAME_W), 32'd1);
            burst_on   = 1;
            beats_left = BURST;
            beat_addr  = s_addr;
            burst_tag  = epoch;
            lat_cnt    = $urandom_range(lat_hi, lat_lo);
            m_idx += BURST;
        end
        if (p_sync) begin
            q.delete();
            m_uf = 0;
            epoch++;
            m_base = p_base;
            m_idx = 0;
            frame_acks = 0;
        end else if (p_vreq) begin
            if (was_empty) m_uf = 1;
            else pop_log.push_back(q.pop_front());
        end
    endtask

    task automatic compare();
        check("vid_data", vid_data, (q.size() > 0) ? q[0] : 32'h0);
        check("underflow", 32'(underflow), 32'(m_uf));
        if (mem_if.mem_req) begin
            check("mem_addr", 32'(mem_if.mem_addr), (32'(m_base) + 32'(m_idx)) & 32'h00FF_FFFF);
            if (!s_mreq) check("space_at_request", 32'(q.size() <= DEPTH - BURST), 32'd1);
        end
        if (!mem_if.mem_req && !burst_on && q.size() <= DEPTH - BURST && m_idx < FRAME_W) stall++;
        else stall = 0;
        check("request_not_stalled", 32'(stall < 4), 32'd1);
    endtask

    task automatic drive_arbiter();
        mem_if.mem_ack    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = $urandom;
        if (mem_if.mem_req && !burst_on) begin
            if (!req_seen) begin
                req_seen = 1;
                wait_cnt = $urandom_range(ack_hi, ack_lo);
            end
            if (wait_cnt == 0) begin
                mem_if.mem_ack = 1'b1;
                req_seen = 0;
            end else wait_cnt--;
        end else req_seen = 0;
        if (burst_on) begin
            if (lat_cnt > 0) lat_cnt--;
            else if ($urandom_range(99, 0) >= gap_pct) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = {8'h00, beat_addr + 24'(BURST - beats_left)};
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        p_sync = frame_sync; p_base = fb_base; p_vreq = vid_req;
        p_ack = mem_if.mem_ack; p_rv = mem_if.mem_rvalid; p_rd = mem_if.mem_rdata;
        model_update();
        compare();
        s_mreq = mem_if.mem_req;
        s_addr = mem_if.mem_addr;
        drive_arbiter();
        frame_sync = 1'b0;
        vid_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        frame_sync = 1'b0; vid_req = 1'b0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
        q.delete(); m_uf = 0; m_base = '0; m_idx = FRAME_W; epoch++;
        burst_on = 0; req_seen = 0; stall = 0; s_mreq = 0; s_addr = '0;
        repeat (2) @(negedge clk);
        check("reset_mem_req", 32'(mem_if.mem_req), 32'd0);
        check("reset_mem_addr", 32'(mem_if.mem_addr), 32'd0);
        check("reset_vid_data", vid_data, 32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic set_fixed();
        ack_lo = 3; ack_hi = 3; lat_lo = 3; lat_hi = 3; gap_pct = 0;
    endtask

    initial begin
        int n;
        int dens;
        epoch = 0; frame_acks = 0;
        set_fixed();
        do_reset();
        repeat (10) step();
        check("no_req_before_sync", 32'(mem_if.mem_req), 32'd0);

        // fill from 0x1000 with no pops: four bursts, then quiet
        frame_sync = 1'b1; fb_base = 24'h1000;
        for (int i = 0; i < 400 && q.size() < DEPTH; i++) step();
        repeat (20) step();
        check("fill_acks", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            check("fill_addr", 32'(ack_log[i]), 32'h1000 + 32'(i * 8));
        check("full_no_req", 32'(mem_if.mem_req), 32'd0);
        check("full_head", vid_data, 32'h1000);

        // 40 pops at one per two cycles; the refill waits for the 8th pop
        for (int i = 0; i < 40; i++) begin
            vid_req = 1'b1; step(); step();
            if (i == 6) begin
                repeat (10) step();
                check("seven_pops_no_req", 32'(ack_log.size()), 32'd4);
            end
        end
        for (int i = 0; i < 40 && i < pop_log.size(); i++)
            check("pop_seq", pop_log[i], 32'h1000 + 32'(i));
        check("pop_count", 32'(pop_log.size()), 32'd40);
        check("no_underflow", 32'(underflow), 32'd0);

        // pop on an empty FIFO right after a frame restart
        frame_sync = 1'b1; fb_base = 24'h2000; step();
        vid_req = 1'b1; step();
        check("empty_pop_underflow", 32'(underflow), 32'd1);
        check("empty_pop_data", vid_data, 32'd0);
        for (int i = 0; i < 100 && q.size() == 0; i++) step();
        check("empty_pop_no_move", vid_data, 32'h2000);

        // restart mid-burst: remainder of the burst must be dropped
        frame_sync = 1'b1; fb_base = 24'h3000; step();
        check("sync_clears_underflow", 32'(underflow), 32'd0);
        for (int i = 0; i < 100 && !(burst_on && beats_left == 4 && burst_tag == epoch); i++) step();
        check("midburst_reached", 32'(beats_left), 32'd4);
        n = ack_log.size();
        frame_sync = 1'b1; fb_base = 24'h5000; step();
        check("flush_empty", vid_data, 32'd0);
        for (int i = 0; i < 100 && ack_log.size() == n; i++) step();
        check("flush_next_addr", 32'(ack_log[$]), 32'h5000);
        for (int i = 0; i < 100 && q.size() == 0; i++) step();
        check("flush_first_word", vid_data, 32'h5000);

        // push and pop together with one word held
        frame_sync = 1'b1; fb_base = 24'h6000; step();
        for (int i = 0; i < 100 && !(q.size() == 1 && mem_if.mem_rvalid); i++) step();
        vid_req = 1'b1; step();
        check("push_pop_head", vid_data, 32'h6001);

        // complete frame: every word delivered exactly once, then empty
        ack_lo = 0; ack_hi = 4; lat_lo = 0; lat_hi = 3; gap_pct = 25;
        frame_sync = 1'b1; fb_base = 24'h8000; step();
        pop_log.delete();
        for (int i = 0; i < 3000 && pop_log.size() < FRAME_W; i++) begin
            vid_req = (q.size() > 0); step();
        end
        repeat (40) step();
        check("frame_acks", 32'(frame_acks), 32'd12);
        check("frame_pops", 32'(pop_log.size()), 32'(FRAME_W));
        for (int i = 0; i < FRAME_W && i < pop_log.size(); i++)
            check("frame_word", pop_log[i], 32'h8000 + 32'(i));
        check("frame_end_empty", vid_data, 32'd0);
        check("frame_end_no_req", 32'(mem_if.mem_req), 32'd0);

        // randomized traffic, restarts near the top of the address space, one mid-run reset
        ack_lo = 0; ack_hi = 5; lat_lo = 0; lat_hi = 4; gap_pct = 30;
        dens = 50;
        for (int c = 0; c < 6000; c++) begin
            if (c % 500 == 0) dens = $urandom_range(90, 10);
            if (c == 3000) begin
                do_reset();
                frame_sync = 1'b1; fb_base = 24'hFFFFF8;
            end else begin
                vid_req = ($urandom_range(99, 0) < dens);
                if ($urandom_range(999, 0) < 6 || c == 0) begin
                    frame_sync = 1'b1;
                    case ($urandom_range(2, 0))
                        0: fb_base = 24'($urandom);
                        1: fb_base = 24'hFFFFE0 + 24'($urandom_range(31, 0));
                        default: fb_base = 24'h1000;
                    endcase
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule
